jk_cmd_debounce: RTL
====================

Name: jk_cmd_debounce

Overview:
- Upstream command stage for the JK flip-flop. Takes three raw asynchronous push-button inputs (set, clear, toggle), then synchronizes, debounces and edge-detects each one.
- Emits one single-cycle {j,k} command per press, through a small lockout FSM.
- When no command is issued, j=k=0, so the downstream JK flop holds its state.

Parameters:
- DB_CYCLES, 4, consecutive stable synchronized cycles required before a debounced level changes (legal range 1 to 2^CNT_W-1).
- CNT_W, 4, width of each per-channel debounce counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- set_in  in  1  raw set button, asynchronous to clk.
- clr_in  in  1  raw clear button, asynchronous to clk.
- tgl_in  in  1  raw toggle button, asynchronous to clk.
- j  out  1  JK command j, registered.
- k  out  1  JK command k, registered.
- cmd_valid  out  1  high for exactly one cycle when j/k carry a command.
- set_db  out  1  debounced set level.
- clr_db  out  1  debounced clear level.
- tgl_db  out  1  debounced toggle level.
- overrun  out  1  sticky flag: a press event was dropped.

Behaviour:
- Reset (rst=0, asynchronous):
  - All flops clear immediately: synchronizers, counters, db levels, delayed db, FSM=IDLE.
  - Outputs j, k, cmd_valid, set_db, clr_db, tgl_db and overrun are all 0.
- Synchronizer: two flops per channel; sN2 is the synchronized level.
- Debounce, per channel:
  - If sN2 != db, the counter increments.
  - When the counter is DB_CYCLES-1 and sN2 still != db, db flips and the counter clears.
  - Any cycle with sN2 == db clears the counter.
  - Latency: a raw change captured at edge 1 flips db at edge 2+DB_CYCLES.
  - A pulse shorter than DB_CYCLES at sN2 is ignored.
  - The counter never wraps: maximum value is DB_CYCLES-1.
- Press event: ev = db & ~db_d, combinational, where db_d is db registered. Falling edges produce no event.
- FSM states: IDLE, ISSUE, LOCKOUT.
  - IDLE: on any ev, go to ISSUE at the next edge.
    - j is registered as ev_set | ev_tgl; k is registered as ev_clr | ev_tgl; cmd_valid is registered as 1.
    - Simultaneous set and clr events give j=1, k=1 (toggle). Any combination is merged into one command.
  - ISSUE: lasts one cycle. At the next edge j, k and cmd_valid return to 0 and the FSM goes to LOCKOUT.
  - LOCKOUT: stays while any of set_db, clr_db, tgl_db is 1. At the first edge where all three are 0, the FSM goes to IDLE.
  - An ev in ISSUE or LOCKOUT is dropped and overrun is set to 1.
- overrun is cleared only by reset.
- Total latency, raw edge to cmd_valid: cmd_valid is high during the cycle after edge 3+DB_CYCLES.
- Holding a button never repeats the command.
- Reset mid-operation: all state is lost and db levels go to 0. A button still held after reset release is therefore a fresh press and issues a new command after the normal latency.
- In every cycle where cmd_valid=0, j=0 and k=0.

Test Plan:
- Reset behaviour: hold rst=0 with all inputs 1 → all outputs 0. Release rst with inputs 0 → outputs stay 0 for 20 cycles.
- Single press, DB_CYCLES=4: set_in=1 held 20 cycles → set_db=1 at edge 6; cmd_valid=1, j=1, k=0 for exactly one cycle after edge 7; no second command while held. Release → FSM back to IDLE about 7 edges later.
- Glitch rejection: tgl_in=1 for 3 cycles, then 0 → tgl_db stays 0, no cmd_valid, overrun=0.
- Simultaneous press: set_in and clr_in rise in the same cycle → exactly one command with j=1, k=1, cmd_valid pulse width 1.
- Overrun: hold set_in; after its command, press tgl_in → no command, overrun=1. Release both, then press clr_in → command j=0, k=1; overrun stays 1.
- Reset during LOCKOUT with set_in held: pull rst low mid-cycle → outputs 0 immediately. Release rst → a new j=1, k=0 command with cmd_valid high after edge 7, counted from release.

Source files
------------

// File: rtl/jk_cmd_debounce.sv
// Push-button front end for a JK flop: synchronize, debounce and edge-detect set/clear/toggle,
// then issue one single-cycle {j,k} command per press through a lockout FSM.
module jk_cmd_debounce #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic set_in,
    input  logic clr_in,
    input  logic tgl_in,
    output logic j,
    output logic k,
    output logic cmd_valid,
    output logic set_db,
    output logic clr_db,
    output logic tgl_db,
    output logic overrun
);

    // Channel index: 0 = set, 1 = clear, 2 = toggle.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    logic [2:0]            s1_q, s1_d;
    logic [2:0]            s2_q, s2_d;
    logic [2:0]            db_q, db_d;
    logic [2:0]            dly_q, dly_d;
    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]            ev;

    state_t state_q, state_d;
    logic   j_q, j_d;
    logic   k_q, k_d;
    logic   cv_q, cv_d;
    logic   ovr_q, ovr_d;

    always_comb begin
        s1_d  = {tgl_in, clr_in, set_in};
        s2_d  = s1_q;
        dly_d = db_q;
        db_d  = db_q;
        cnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            // Counter only runs while the synchronized level disagrees; it saturates by flipping db.
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign ev = db_q & ~dly_q;

    always_comb begin
        state_d = state_q;
        j_d     = 1'b0;
        k_d     = 1'b0;
        cv_d    = 1'b0;
        ovr_d   = ovr_q;
        unique case (state_q)
            IDLE: begin
                if (|ev) begin
                    state_d = ISSUE;
                    j_d     = ev[0] | ev[2];
                    k_d     = ev[1] | ev[2];
                    cv_d    = 1'b1;
                end
            end
            ISSUE: begin
                state_d = LOCKOUT;
                if (|ev) ovr_d = 1'b1;
            end
            LOCKOUT: begin
                if (|ev) ovr_d = 1'b1;
                if (db_q == 3'b000) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            db_q    <= '0;
            dly_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            cv_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            db_q    <= db_d;
            dly_q   <= dly_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            j_q     <= j_d;
            k_q     <= k_d;
            cv_q    <= cv_d;
            ovr_q   <= ovr_d;
        end
    end

    assign j         = j_q;
    assign k         = k_q;
    assign cmd_valid = cv_q;
    assign set_db    = db_q[0];
    assign clr_db    = db_q[1];
    assign tgl_db    = db_q[2];
    assign overrun   = ovr_q;

endmodule
